// File: rtl/maxi_burst_pkg.sv
// Shared types and AXI constants for the burst writer slice.
package maxi_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/maxi_burst_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst writer and the DDR port.
// Every channel transfers on the rising clock edge where valid and ready are both high;
// the source holds valid and payload unchanged until that edge and never waits for ready.
interface maxi_burst_writer_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0]   m_awaddr;
  logic [7:0]          m_awlen;
  logic [2:0]          m_awsize;
  logic [1:0]          m_awburst;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wlast;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;

  modport master (
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/maxi_wbuf.sv
// First-word-fall-through circular buffer; a full buffer still accepts a push when a pop frees a slot.
module maxi_wbuf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_en;
  logic              wr_en;

  assign rd_en    = pop && (count != '0);
  assign wr_en    = push && ((count < CNT_W'(DEPTH)) || rd_en);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !wr_en) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/maxi_burst_writer.sv
// Buffers an unthrottled word stream and writes it out as fixed-length AXI4 INCR bursts
// into a circular DDR region, granting the upstream stage burst permission via buf_ready.
module maxi_burst_writer
  import maxi_burst_pkg::*;
#(
  parameter int                DATA_W        = 64,
  parameter int                ADDR_W        = 32,
  parameter int                BURST_LEN     = 256,
  parameter int                BUF_DEPTH     = 512,
  parameter int                GUARD         = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 'h1000_0000,
  parameter int                REGION_BURSTS = 1024
) (
  input  logic                       read_clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       buf_ready,
  maxi_burst_writer_if.master        m_axi,
  output logic                       overflow,
  output logic                       resp_err,
  output logic [15:0]                burst_cnt,
  output wr_state_t                  dbg_state,
  output logic [$clog2(BUF_DEPTH):0] dbg_count
);
  localparam int                CNT_W       = $clog2(BUF_DEPTH) + 1;
  localparam int                FREE_MIN    = BURST_LEN + GUARD;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * beat_bytes(DATA_W));
  localparam logic [2:0]        AW_SIZE     = 3'($clog2(beat_bytes(DATA_W)));

  wr_state_t         state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic [7:0]        beat_idx;
  logic [31:0]       region_idx;

  // W only runs in DATA, so every accepted beat is exactly one buffer pop.
  assign pop = m_axi.m_wvalid & m_axi.m_wready;

  maxi_wbuf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_wbuf (
    .clk       (read_clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (head_data),
    .count     (count),
    .overflow  (overflow)
  );

  assign m_axi.m_wdata   = head_data;
  assign m_axi.m_wstrb   = '1;
  assign m_axi.m_awlen   = 8'(BURST_LEN - 1);
  assign m_axi.m_awsize  = AW_SIZE;
  assign m_axi.m_awburst = AXI_BURST_INCR;
  assign dbg_state       = state;
  assign dbg_count       = count;

  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      m_axi.m_awvalid <= 1'b0;
      m_axi.m_wvalid  <= 1'b0;
      m_axi.m_wlast   <= 1'b0;
      m_axi.m_bready  <= 1'b0;
      m_axi.m_awaddr  <= BASE_ADDR;
      region_idx      <= '0;
      beat_idx        <= '0;
      burst_cnt       <= '0;
      resp_err        <= 1'b0;
      buf_ready       <= 1'b0;
    end else begin
      buf_ready <= (BUF_DEPTH - int'(count)) >= FREE_MIN;
      case (state)
        IDLE: begin
          // A whole burst is committed before AW, so DATA can never starve.
          if (int'(count) >= BURST_LEN) begin
            m_axi.m_awvalid <= 1'b1;
            state           <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi.m_awready) begin
            m_axi.m_awvalid <= 1'b0;
            m_axi.m_wvalid  <= 1'b1;
            m_axi.m_wlast   <= (BURST_LEN == 1);
            beat_idx        <= '0;
            state           <= DATA;
          end
        end
        DATA: begin
          if (m_axi.m_wready) begin
            if (m_axi.m_wlast) begin
              m_axi.m_wvalid <= 1'b0;
              m_axi.m_wlast  <= 1'b0;
              m_axi.m_bready <= 1'b1;
              state          <= RESP;
            end else begin
              beat_idx      <= beat_idx + 1'b1;
              m_axi.m_wlast <= (int'(beat_idx) + 2 == BURST_LEN);
            end
          end
        end
        RESP: begin
          if (m_axi.m_bvalid) begin
            m_axi.m_bready <= 1'b0;
            burst_cnt      <= burst_cnt + 1'b1;
            resp_err       <= resp_err | m_axi.m_bresp[1];
            if (region_idx == 32'(REGION_BURSTS - 1)) begin
              m_axi.m_awaddr <= BASE_ADDR;
              region_idx     <= '0;
            end else begin
              m_axi.m_awaddr <= m_axi.m_awaddr + BURST_BYTES;
              region_idx     <= region_idx + 1'b1;
            end
            state <= IDLE;
          end
        end
        default: begin
          m_axi.m_awvalid <= 1'b0;
          m_axi.m_wvalid  <= 1'b0;
          m_axi.m_wlast   <= 1'b0;
          m_axi.m_bready  <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_maxi_burst_writer.sv
// Directed bench for maxi_burst_writer with a two-burst region, a reactive AXI slave
// and a queue-based scoreboard for AW addresses and W data.
module tb_maxi_burst_writer;
  import maxi_burst_pkg::*;

  localparam int          DW    = 64;
  localparam int          BL    = 256;
  localparam int          DEPTH = 512;
  localparam int          RB    = 2;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] BB    = 32'h0000_0800;

  // clock / reset
  logic          read_clk = 1'b0;
  logic          reset    = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          buf_ready;
  logic          overflow;
  logic          resp_err;
  logic [15:0]   burst_cnt;
  wr_state_t     dbg_state;
  logic [9:0]    dbg_count;

  always #5 read_clk = ~read_clk;

  maxi_burst_writer_if #(.DATA_W(DW), .ADDR_W(32)) axi ();

  maxi_burst_writer #(.REGION_BURSTS(RB)) dut (
    .read_clk  (read_clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .buf_ready (buf_ready),
    .m_axi     (axi),
    .overflow  (overflow),
    .resp_err  (resp_err),
    .burst_cnt (burst_cnt),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // scoreboard state
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [31:0]   exp_aw_q[$];
  int            aw_mode  = 1;
  int            w_mode   = 0;
  logic [1:0]    next_bresp = 2'b00;
  int            mon_beat = 0;
  int            w_cycles = 0;
  int            burst_no = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s observed=beat expected=none", tag);
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge read_clk);
      #1;
    end
  endtask

  task automatic expect_aw();
    exp_aw_q.push_back(BASE + 32'(burst_no % RB) * BB);
    burst_no++;
  endtask

  task automatic push_burst(input logic [DW-1:0] first);
    for (int i = 0; i < BL; i++) begin
      @(posedge read_clk);
      #1;
      in_valid = 1'b1;
      in_data  = first + DW'(i);
      exp_q.push_back(first + DW'(i));
    end
    @(posedge read_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_bursts(input int target);
    int k;
    k = 0;
    while (burst_cnt !== 16'(target) && k < 3000) begin
      @(posedge read_clk);
      #1;
      k++;
    end
    check("burst_cnt", burst_cnt, 64'(target));
  endtask

  // AXI slave: AW/W readiness by mode, one B response per completed burst
  initial begin
    logic w_done;
    logic b_done;
    logic nxt_wready;
    axi.m_awready = 1'b1;
    axi.m_wready  = 1'b1;
    axi.m_bvalid  = 1'b0;
    axi.m_bresp   = 2'b00;
    forever begin
      @(negedge read_clk);
      w_done     = axi.m_wvalid & axi.m_wready & axi.m_wlast;
      b_done     = axi.m_bvalid & axi.m_bready;
      nxt_wready = (w_mode == 0 || !axi.m_wvalid) ? 1'b1 : ~axi.m_wready;
      @(posedge read_clk);
      #1;
      axi.m_awready = (aw_mode != 0);
      axi.m_wready  = nxt_wready;
      if (reset || b_done) axi.m_bvalid = 1'b0;
      if (!reset && w_done) begin
        axi.m_bvalid = 1'b1;
        axi.m_bresp  = next_bresp;
      end
    end
  end

  // monitor: compares AW and W traffic against the expected queues
  initial begin
    logic [DW-1:0] held;
    logic          stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge read_clk);
      if (reset) begin
        mon_beat = 0;
        stalled  = 1'b0;
      end else begin
        if (stalled && axi.m_wvalid) check("wdata_stable", axi.m_wdata, held);
        if (axi.m_wvalid) w_cycles++;
        if (axi.m_awvalid && axi.m_awready) begin
          if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
          else check("awaddr", 64'(axi.m_awaddr), 64'(exp_aw_q.pop_front()));
        end
        if (axi.m_wvalid && axi.m_wready) begin
          if (exp_q.size() == 0) fail_now("w_unexpected");
          else check("wdata", axi.m_wdata, exp_q.pop_front());
          check("wlast", 64'(axi.m_wlast), 64'(mon_beat == BL - 1));
          mon_beat = (mon_beat == BL - 1) ? 0 : mon_beat + 1;
        end
        stalled = axi.m_wvalid & ~axi.m_wready;
        held    = axi.m_wdata;
      end
    end
  end

  // directed sequence
  initial begin
    int  mcnt;
    logic mrdy;
    int  k;

    tick(3);
    check("rst_awvalid", 64'(axi.m_awvalid), 0);
    check("rst_wvalid", 64'(axi.m_wvalid), 0);
    check("rst_wlast", 64'(axi.m_wlast), 0);
    check("rst_bready", 64'(axi.m_bready), 0);
    check("rst_buf_ready", 64'(buf_ready), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_resp_err", 64'(resp_err), 0);
    check("rst_burst_cnt", 64'(burst_cnt), 0);
    check("rst_awaddr", 64'(axi.m_awaddr), 64'(BASE));
    check("rst_count", 64'(dbg_count), 0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("awlen", 64'(axi.m_awlen), 255);
    check("awsize", 64'(axi.m_awsize), 3);
    check("awburst", 64'(axi.m_awburst), 1);
    check("wstrb", 64'(axi.m_wstrb), 64'hff);
    reset = 1'b0;
    tick(2);
    check("ready_after_rst", 64'(buf_ready), 1);

    // single burst, slave always ready
    expect_aw();
    push_burst(64'd0);
    wait_bursts(1);
    tick(2);
    check("b1_buf_ready", 64'(buf_ready), 1);
    check("b1_count", 64'(dbg_count), 0);
    check("b1_w_drained", 64'(exp_q.size()), 0);

    // W backpressure, ready toggling every cycle
    w_mode   = 1;
    w_cycles = 0;
    expect_aw();
    push_burst(64'd1000);
    wait_bursts(2);
    tick(2);
    check("bp_w_cycles", 64'(w_cycles), 511);
    check("bp_resp_err", 64'(resp_err), 0);
    w_mode = 0;

    // error response on the third burst, address wraps back to base
    next_bresp = 2'b10;
    expect_aw();
    push_burst(64'd2000);
    wait_bursts(3);
    tick(1);
    check("err_resp_err", 64'(resp_err), 1);
    next_bresp = 2'b00;
    expect_aw();
    push_burst(64'd3000);
    wait_bursts(4);
    check("err_sticky", 64'(resp_err), 1);

    // overflow with AW stalled
    aw_mode = 0;
    tick(2);
    expect_aw();
    expect_aw();
    mcnt = 0;
    mrdy = 1'b1;
    for (int i = 0; i <= 600; i++) begin
      @(posedge read_clk);
      #1;
      mrdy = (DEPTH - mcnt) >= BL + 4;
      if (i > 0 && mcnt < DEPTH) mcnt++;
      check("ovf_count", 64'(dbg_count), 64'(mcnt));
      check("ovf_buf_ready", 64'(buf_ready), 64'(mrdy));
      check("ovf_flag", 64'(overflow), 64'(i >= 513));
      if (i < 600) begin
        in_valid = 1'b1;
        in_data  = 64'(6000 + i);
        if (i < DEPTH) exp_q.push_back(64'(6000 + i));
      end else begin
        in_valid = 1'b0;
      end
    end
    tick(3);
    check("ovf_full", 64'(dbg_count), 512);
    check("ovf_sticky", 64'(overflow), 1);
    check("ovf_not_ready", 64'(buf_ready), 0);
    check("ovf_state_addr", 64'(dbg_state), 64'(ADDR));
    aw_mode = 1;
    wait_bursts(6);
    tick(2);
    check("drain_count", 64'(dbg_count), 0);
    check("drain_ready", 64'(buf_ready), 1);
    check("drain_w_empty", 64'(exp_q.size()), 0);

    // reset while the burst sits at beat 100
    expect_aw();
    push_burst(64'd4000);
    k = 0;
    while (!(mon_beat == 100 && axi.m_wvalid) && k < 2000) begin
      tick(1);
      k++;
    end
    check("beat100_reached", 64'(mon_beat), 100);
    check("beat100_data", axi.m_wdata, 64'd4100);
    reset = 1'b1;
    #1;
    check("mid_rst_wvalid", 64'(axi.m_wvalid), 0);
    check("mid_rst_awvalid", 64'(axi.m_awvalid), 0);
    check("mid_rst_wlast", 64'(axi.m_wlast), 0);
    check("mid_rst_count", 64'(dbg_count), 0);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    check("mid_rst_awaddr", 64'(axi.m_awaddr), 64'(BASE));
    check("mid_rst_burst_cnt", 64'(burst_cnt), 0);
    check("mid_rst_overflow", 64'(overflow), 0);
    check("mid_rst_resp_err", 64'(resp_err), 0);
    exp_q.delete();
    burst_no = 0;
    tick(2);
    reset = 1'b0;
    tick(3);
    check("post_rst_count", 64'(dbg_count), 0);
    check("post_rst_state", 64'(dbg_state), 64'(IDLE));
    check("post_rst_awaddr", 64'(axi.m_awaddr), 64'(BASE));
    check("post_rst_ready", 64'(buf_ready), 1);
    check("post_rst_wvalid", 64'(axi.m_wvalid), 0);

    // recovery burst after the abandoned one
    expect_aw();
    push_burst(64'd5000);
    wait_bursts(1);
    tick(2);
    check("final_w_empty", 64'(exp_q.size()), 0);
    check("final_aw_empty", 64'(exp_aw_q.size()), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
